// File: rtl/wb_pkg.sv
// Shared definitions for the writeback retire queue: width helpers and exception codes.
package wb_pkg;

  localparam int EXCODE_W = 5;

  localparam logic [EXCODE_W-1:0] EXC_INT  = 5'h00;
  localparam logic [EXCODE_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [EXCODE_W-1:0] EXC_ADES = 5'h05;
  localparam logic [EXCODE_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [EXCODE_W-1:0] EXC_BP   = 5'h09;
  localparam logic [EXCODE_W-1:0] EXC_RI   = 5'h0a;
  localparam logic [EXCODE_W-1:0] EXC_OV   = 5'h0c;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fwd_search.sv
// Youngest-match forwarding search over the queued results, presented oldest (index 0) first.
module wb_fwd_search
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BE_W   = be_width(DATA_W)
) (
  input  logic              valid  [DEPTH],
  input  logic [BE_W-1:0]   we     [DEPTH],
  input  logic [ADDR_W-1:0] dest   [DEPTH],
  input  logic [DATA_W-1:0] result [DEPTH],
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic              fwd_busy,
  output logic [DATA_W-1:0] fwd_data
);

  // Later (younger) matches overwrite earlier ones, so the youngest producer decides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_busy = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (fwd_addr != '0) && (dest[i] == fwd_addr) && (we[i] != '0)) begin
        fwd_hit  = &we[i];
        fwd_busy = ~&we[i];
        fwd_data = (&we[i]) ? result[i] : '0;
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Writeback stage: in-order retire queue draining to the RF write port, with precise
// exception flush and a forwarding lookup over every queued result.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int BE_W  = be_width(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ms_to_ws_valid,
  output logic                ws_allowin,
  input  logic [BE_W-1:0]     ms_we,
  input  logic [ADDR_W-1:0]   ms_dest,
  input  logic [DATA_W-1:0]   ms_result,
  input  logic [31:0]         ms_pc,
  input  logic                ms_ex,
  input  logic [EXCODE_W-1:0] ms_excode,
  input  logic                rf_ready,
  output logic [BE_W-1:0]     rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                ws_ex,
  output logic [31:0]         ws_ex_pc,
  output logic [EXCODE_W-1:0] ws_excode,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic                fwd_busy,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [31:0]         debug_wb_pc,
  output logic [BE_W-1:0]     debug_wb_rf_wen,
  output logic [ADDR_W-1:0]   debug_wb_rf_wnum,
  output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [BE_W-1:0]     we;
    logic [ADDR_W-1:0]   dest;
    logic [DATA_W-1:0]   result;
    logic [31:0]         pc;
    logic                ex;
    logic [EXCODE_W-1:0] excode;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  entry_t           mem [DEPTH];
  entry_t           head_e;
  entry_t           in_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             head_vld;
  logic             pop;
  logic             push;
  logic             flush;

  assign in_e     = '{we: ms_we, dest: ms_dest, result: ms_result, pc: ms_pc,
                      ex: ms_ex, excode: ms_excode};
  assign head_e   = mem[head];
  assign head_vld = (count != '0);
  assign flush    = head_vld && head_e.ex && !reset;
  assign pop      = head_vld && (head_e.ex || (head_e.we == '0) || rf_ready);
  assign ws_allowin = (count < CNT_FULL) || pop;
  // An enqueue that coincides with an exception flush is dropped with the rest of the queue.
  assign push     = ms_to_ws_valid && ws_allowin && !flush;

  assign rf_we     = head_e.we & {BE_W{head_vld && !head_e.ex && rf_ready && !reset}};
  assign rf_waddr  = head_e.dest;
  assign rf_wdata  = head_e.result;
  assign ws_ex     = flush;
  assign ws_ex_pc  = head_e.pc;
  assign ws_excode = head_e.excode;

  assign debug_wb_pc       = head_e.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = head_e.dest;
  assign debug_wb_rf_wdata = head_e.result;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_e;
  end

  // Re-order storage by age for the forwarding search; excepting entries never forward.
  logic              age_vld [DEPTH];
  logic [BE_W-1:0]   age_we  [DEPTH];
  logic [ADDR_W-1:0] age_dest[DEPTH];
  logic [DATA_W-1:0] age_res [DEPTH];

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      age_vld[i]  = (CNT_W'(i) < count) && !mem[idx].ex;
      age_we[i]   = mem[idx].we;
      age_dest[i] = mem[idx].dest;
      age_res[i]  = mem[idx].result;
      idx = ptr_inc(idx);
    end
  end

  wb_fwd_search #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BE_W  (BE_W)
  ) u_fwd (
    .valid   (age_vld),
    .we      (age_we),
    .dest    (age_dest),
    .result  (age_res),
    .fwd_addr(fwd_addr),
    .fwd_hit (fwd_hit),
    .fwd_busy(fwd_busy),
    .fwd_data(fwd_data)
  );

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: directed scenarios, random traffic and a DEPTH=3 wrap run.
module tb_wb_retire_queue;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ms_to_ws_valid, ws_allowin, ms_ex, rf_ready, ws_ex, fwd_hit, fwd_busy;
  logic [3:0]  ms_we, rf_we, dbg_wen;
  logic [4:0]  ms_dest, rf_waddr, fwd_addr, dbg_wnum, ms_excode, ws_excode;
  logic [31:0] ms_result, ms_pc, rf_wdata, ws_ex_pc, fwd_data, dbg_pc, dbg_wdata;

  logic        v3, allowin3, rdy3, ex3o, hit3, busy3;
  logic [3:0]  we3, rf_we3, wen3;
  logic [4:0]  dest3, waddr3, code3, fwd3, wnum3;
  logic [31:0] res3, pc3, wdata3, expc3, fdata3, dpc3, dwdata3;

  wb_retire_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_we(ms_we), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc), .ms_ex(ms_ex),
    .ms_excode(ms_excode), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_ex(ws_ex), .ws_ex_pc(ws_ex_pc), .ws_excode(ws_excode),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_busy(fwd_busy), .fwd_data(fwd_data),
    .debug_wb_pc(dbg_pc), .debug_wb_rf_wen(dbg_wen), .debug_wb_rf_wnum(dbg_wnum),
    .debug_wb_rf_wdata(dbg_wdata));

  wb_retire_queue #(.DEPTH(3), .DATA_W(32), .ADDR_W(5)) dut3 (
    .clk(clk), .reset(reset), .ms_to_ws_valid(v3), .ws_allowin(allowin3),
    .ms_we(we3), .ms_dest(dest3), .ms_result(res3), .ms_pc(pc3), .ms_ex(1'b0),
    .ms_excode(5'h00), .rf_ready(rdy3), .rf_we(rf_we3), .rf_waddr(waddr3),
    .rf_wdata(wdata3), .ws_ex(ex3o), .ws_ex_pc(expc3), .ws_excode(code3),
    .fwd_addr(fwd3), .fwd_hit(hit3), .fwd_busy(busy3), .fwd_data(fdata3),
    .debug_wb_pc(dpc3), .debug_wb_rf_wen(wen3), .debug_wb_rf_wnum(wnum3),
    .debug_wb_rf_wdata(dwdata3));

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  excode;
  } ent_t;

  ent_t exp_q[$];
  ent_t exp3_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc3 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] we, input logic [4:0] d,
                        input logic [31:0] r, input logic [31:0] pc,
                        input logic ex = 1'b0, input logic [4:0] code = 5'h00);
    ms_to_ws_valid = v; ms_we = we; ms_dest = d; ms_result = r; ms_pc = pc;
    ms_ex = ex; ms_excode = code;
  endtask

  task automatic idle();
    set_in(1'b0, 4'h0, 5'd0, 32'h0, 32'h0);
  endtask

  // Accepted entries become expectations at the negedge, then the next cycle starts.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      exp3_q.delete();
    end else begin
      if (ms_to_ws_valid && ws_allowin && !ws_ex)
        exp_q.push_back('{ms_we, ms_dest, ms_result, ms_pc, ms_ex, ms_excode});
      if (v3 && allowin3) begin
        exp3_q.push_back('{we3, dest3, res3, pc3, 1'b0, 5'h00});
        acc3++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void model_fwd(input logic [4:0] a, output logic h, output logic b,
                                    output logic [31:0] d);
    h = 1'b0; b = 1'b0; d = '0;
    if (a != 5'd0) begin
      foreach (exp_q[i]) begin
        if (!exp_q[i].ex && exp_q[i].we != 4'h0 && exp_q[i].dest == a) begin
          h = (exp_q[i].we == 4'hf);
          b = !h;
          d = h ? exp_q[i].result : 32'h0;
        end
      end
    end
  endfunction

  // Monitor: checks forwarding every cycle and every retirement against the expectation queues.
  initial begin
    logic        eh, eb;
    logic [31:0] ed;
    ent_t        e;
    forever begin
      @(posedge clk);
      #3;
      if (reset) begin
        check("rst_no_we", rf_we, 0);
        check("rst_no_ex", ws_ex, 0);
        check("rst_no_we3", rf_we3, 0);
      end else begin
        model_fwd(fwd_addr, eh, eb, ed);
        check("fwd_hit", fwd_hit, eh);
        check("fwd_busy", fwd_busy, eb);
        if (eh) check("fwd_data", fwd_data, ed);
        if (rf_we != 4'h0 || ws_ex) begin
          while (exp_q.size() > 0 && !exp_q[0].ex && exp_q[0].we == 4'h0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            check("spurious_retire", {ws_ex, rf_we}, 0);
          end else begin
            e = exp_q.pop_front();
            check("retire_kind_ex", ws_ex, e.ex);
            if (e.ex) begin
              check("ex_pc", ws_ex_pc, e.pc);
              check("ex_code", ws_excode, e.excode);
              check("ex_no_we", rf_we, 0);
              exp_q.delete();
            end else begin
              check("rf_we", rf_we, e.we);
              check("rf_waddr", rf_waddr, e.dest);
              check("rf_wdata", rf_wdata, e.result);
              check("dbg_pc", dbg_pc, e.pc);
              check("dbg_wen", dbg_wen, e.we);
              check("dbg_wnum", dbg_wnum, e.dest);
              check("dbg_wdata", dbg_wdata, e.result);
            end
          end
        end
        if (rf_we3 != 4'h0) begin
          if (exp3_q.size() == 0) begin
            check("w3_spurious", rf_we3, 0);
          end else begin
            e = exp3_q.pop_front();
            check("w3_waddr", waddr3, e.dest);
            check("w3_wdata", wdata3, e.result);
            check("w3_pc", dpc3, e.pc);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    rf_ready = 1'b0;
    fwd_addr = 5'd1;
    v3 = 1'b0; we3 = 4'hf; dest3 = 5'd0; res3 = '0; pc3 = '0; rdy3 = 1'b0; fwd3 = 5'd0;
    @(posedge clk); #1;
    tick();
    #1;
    check("rst_allowin", ws_allowin, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_ws_ex", ws_ex, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_fwd_busy", fwd_busy, 0);
    reset = 1'b0;
    tick();

    // back-to-back pushes retire in order, one per cycle
    rf_ready = 1'b1;
    set_in(1'b1, 4'hf, 5'd5, 32'h11, 32'h100);
    #1 check("t1_latency", rf_we, 0);
    tick();
    set_in(1'b1, 4'hf, 5'd6, 32'h22, 32'h104);
    #1;
    check("t1_we0", rf_we, 4'hf);
    check("t1_addr0", rf_waddr, 5);
    check("t1_data0", rf_wdata, 32'h11);
    check("t1_pc0", dbg_pc, 32'h100);
    tick();
    idle();
    #1;
    check("t1_addr1", rf_waddr, 6);
    check("t1_data1", rf_wdata, 32'h22);
    check("t1_pc1", dbg_pc, 32'h104);
    tick();
    #1 check("t1_empty", rf_we, 0);

    // fill with port stalled, then drain
    rf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'hf, 5'(10 + i), 32'h1000 + i, 32'h200 + 4 * i);
      #1 check("t2_allowin", ws_allowin, i < 4);
      tick();
    end
    idle();
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_we", rf_we, 4'hf);
      check("t2_addr", rf_waddr, 10 + i);
      tick();
    end
    #1 check("t2_done", rf_we, 0);

    // precise exception
    set_in(1'b1, 4'hf, 5'd1, 32'h1111, 32'h14);
    tick();
    set_in(1'b1, 4'hf, 5'd7, 32'h7777, 32'h1c, 1'b1, EXC_ADEL);
    #1;
    check("t3_x1_we", rf_we, 4'hf);
    check("t3_x1_addr", rf_waddr, 1);
    tick();
    set_in(1'b1, 4'hf, 5'd2, 32'h2222, 32'h20);
    #1;
    check("t3_ex", ws_ex, 1);
    check("t3_ex_pc", ws_ex_pc, 32'h1c);
    check("t3_excode", ws_excode, 5'h04);
    check("t3_ex_no_we", rf_we, 0);
    tick();
    idle();
    #1;
    check("t3_ex_once", ws_ex, 0);
    check("t3_x2_dropped", rf_we, 0);
    check("t3_allowin", ws_allowin, 1);
    tick();
    #1 check("t3_still_empty", rf_we, 0);

    // forwarding: full then partial producer of x3
    rf_ready = 1'b0;
    fwd_addr = 5'd3;
    set_in(1'b1, 4'hf, 5'd3, 32'hAAAA_AAAA, 32'h30);
    tick();
    set_in(1'b1, 4'h1, 5'd3, 32'h55, 32'h34);
    #1;
    check("t4_hit_full", fwd_hit, 1);
    check("t4_data_full", fwd_data, 32'hAAAA_AAAA);
    check("t4_busy_full", fwd_busy, 0);
    tick();
    idle();
    #1;
    check("t4_busy", fwd_busy, 1);
    check("t4_nohit", fwd_hit, 0);
    rf_ready = 1'b1;
    tick();
    #1 check("t4_busy_popping", fwd_busy, 1);
    tick();
    #1;
    check("t4_busy_gone", fwd_busy, 0);
    check("t4_hit_gone", fwd_hit, 0);

    // register 0 never forwards
    rf_ready = 1'b0;
    fwd_addr = 5'd0;
    set_in(1'b1, 4'hf, 5'd0, 32'hDEAD, 32'h40);
    tick();
    idle();
    #1;
    check("t5_x0_hit", fwd_hit, 0);
    check("t5_x0_busy", fwd_busy, 0);
    rf_ready = 1'b1;
    tick();
    tick();

    // reset mid-operation drops queued entries
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'hf, 5'(20 + i), 32'h500 + i, 32'h500 + 4 * i);
      tick();
    end
    idle();
    reset = 1'b1;
    rf_ready = 1'b1;
    #1 check("t6_we_in_reset", rf_we, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_allowin", ws_allowin, 1);
    check("t6_no_we", rf_we, 0);
    tick();
    #1 check("t6_no_we_after", rf_we, 0);

    // random traffic against the scoreboard
    for (int c = 0; c < 500; c++) begin
      ms_to_ws_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       ms_we = 4'h0;
        2:       ms_we = 4'($urandom_range(1, 14));
        default: ms_we = 4'hf;
      endcase
      ms_dest   = 5'($urandom_range(0, 3));
      ms_result = $urandom;
      ms_pc     = 32'h1000 + 4 * c;
      ms_ex     = ($urandom_range(0, 11) == 0);
      ms_excode = 5'($urandom_range(0, 31));
      rf_ready  = ($urandom_range(0, 3) != 0);
      fwd_addr  = 5'($urandom_range(0, 3));
      tick();
    end
    idle();
    rf_ready = 1'b1;
    repeat (8) tick();
    while (exp_q.size() > 0 && !exp_q[0].ex && exp_q[0].we == 4'h0) void'(exp_q.pop_front());
    check("rand_drained", exp_q.size(), 0);

    // DEPTH=3 instance: ten entries through wrapping pointers
    acc3 = 0;
    for (int c = 0; c < 200 && acc3 < 10; c++) begin
      v3    = 1'b1;
      dest3 = 5'($urandom_range(1, 31));
      res3  = $urandom;
      pc3   = 32'h300 + 4 * acc3;
      rdy3  = ($urandom_range(0, 2) != 0);
      tick();
    end
    v3 = 1'b0;
    rdy3 = 1'b1;
    repeat (6) tick();
    check("w3_accepted", acc3, 10);
    check("w3_drained", exp3_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
